// File: rtl/acia_link_rx.sv
// Far-end 8N1 receiver for the ACIA transmit line: FWFT byte FIFO, valid/ready stream and CTS.
// Define RX_PARITY_EN to expect a parity bit (sense set by PARITY_ODD) between data and stop.
module acia_link_rx #(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_AW    = 4,
   parameter int CTS_MARGIN = 2,
   parameter int PARITY_ODD = 0
) (
   input  logic               fst_clk,
   input  logic               res_n,
   input  logic               rxd,
   output logic               cts_n,
   output logic [7:0]         m_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               frame_err,
   output logic               parity_err,
   output logic               overrun,
   input  logic               clr_err
);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0]   LEVEL_ZERO = (FIFO_AW+1)'(0);
   localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0]   CTS_LEVEL  = (FIFO_AW+1)'(DEPTH - CTS_MARGIN);
   localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
   localparam logic [15:0]        DIV_LAST   = 16'(CLK_DIV - 1);
   localparam logic               PAR_ODD    = 1'(PARITY_ODD);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   function automatic logic parity_bit(input logic [7:0] data);
      return (^data) ^ PAR_ODD;
   endfunction

   state_t             state_r, state_s;
   logic               sync1_r, sync2_r, prev_r;
   logic [15:0]        div_r;
   logic [3:0]         sc_r, sc_s;
   logic [2:0]         bit_r, bit_s;
   logic [7:0]         shift_r, shift_s;
   logic               par_bad_r, par_bad_s;
   logic [7:0]         mem_r [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r, rd_nx_s;
   logic [FIFO_AW:0]   level_r, level_nx_s;
   logic [7:0]         head_s, m_data_r;
   logic               m_valid_r, cts_n_r, frame_err_r, parity_err_r, overrun_r;
   logic               rxd_s, fall_s, tick_s, div_clr_s, push_s, ferr_set_s, perr_set_s;
   logic               pop_s, wr_en_s, ovr_set_s;

   assign rxd_s  = sync2_r;
   assign fall_s = prev_r & ~sync2_r;
   assign tick_s = (div_r == DIV_LAST);

   // Input synchronizer, edge history and free-running oversample divider
   always_ff @(posedge fst_clk) begin
      if (!res_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         prev_r  <= 1'b1;
         div_r   <= 16'd0;
      end else begin
         sync1_r <= rxd;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
         if (div_clr_s || tick_s) div_r <= 16'd0;
         else                     div_r <= div_r + 16'd1;
      end
   end

   // Receiver state and datapath registers
   always_ff @(posedge fst_clk) begin
      if (!res_n) begin
         state_r   <= ST_IDLE;
         sc_r      <= 4'd0;
         bit_r     <= 3'd0;
         shift_r   <= 8'h00;
         par_bad_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         sc_r      <= sc_s;
         bit_r     <= bit_s;
         shift_r   <= shift_s;
         par_bad_r <= par_bad_s;
      end
   end

   // Frame sequencing: mid-bit sampling on sample count 15 (7 for the start bit)
   always_comb begin
      state_s    = state_r;
      sc_s       = sc_r;
      bit_s      = bit_r;
      shift_s    = shift_r;
      par_bad_s  = par_bad_r;
      div_clr_s  = 1'b0;
      push_s     = 1'b0;
      ferr_set_s = 1'b0;
      perr_set_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fall_s) begin
               state_s   = ST_START;
               sc_s      = 4'd0;
               div_clr_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s && (sc_r == 4'd7)) begin
               if (rxd_s) begin
                  state_s = ST_IDLE;
               end else begin
                  state_s   = ST_DATA;
                  sc_s      = 4'd0;
                  bit_s     = 3'd0;
                  par_bad_s = 1'b0;
               end
            end else if (tick_s) begin
               sc_s = sc_r + 4'd1;
            end else begin
               sc_s = sc_r;
            end
         end
         ST_DATA: begin
            if (tick_s) begin
               sc_s = sc_r + 4'd1;
               if (sc_r == 4'd15) begin
                  shift_s = {rxd_s, shift_r[7:1]};
                  if (bit_r == 3'd7) begin
`ifdef RX_PARITY_EN
                     state_s = ST_PARITY;
`else
                     state_s = ST_STOP;
`endif
                  end else begin
                     bit_s = bit_r + 3'd1;
                  end
               end else begin
                  shift_s = shift_r;
               end
            end else begin
               sc_s = sc_r;
            end
         end
         ST_PARITY: begin
`ifdef RX_PARITY_EN
            if (tick_s) begin
               sc_s = sc_r + 4'd1;
               if (sc_r == 4'd15) begin
                  par_bad_s = (rxd_s != parity_bit(shift_r));
                  state_s   = ST_STOP;
               end else begin
                  state_s = ST_PARITY;
               end
            end else begin
               state_s = ST_PARITY;
            end
`else
            state_s = ST_IDLE;
`endif
         end
         ST_STOP: begin
            if (tick_s && (sc_r == 4'd15)) begin
               state_s    = ST_IDLE;
               sc_s       = 4'd0;
               perr_set_s = par_bad_r;
               if (rxd_s) begin
                  push_s = !par_bad_r;
               end else begin
                  ferr_set_s = 1'b1;
               end
            end else if (tick_s) begin
               sc_s = sc_r + 4'd1;
            end else begin
               sc_s = sc_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FIFO bookkeeping; head is precomputed so m_data can be registered
   always_comb begin
      pop_s      = m_ready && (level_r != LEVEL_ZERO);
      wr_en_s    = push_s && ((level_r != LEVEL_FULL) || pop_s);
      ovr_set_s  = push_s && (level_r == LEVEL_FULL) && !pop_s;
      level_nx_s = level_r + {{FIFO_AW{1'b0}}, wr_en_s} - {{FIFO_AW{1'b0}}, pop_s};
      rd_nx_s    = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      if (level_nx_s == LEVEL_ZERO) begin
         head_s = 8'h00;
      end else if (wr_en_s && (rd_nx_s == wr_ptr_r)) begin
         head_s = shift_r;
      end else begin
         head_s = mem_r[rd_nx_s];
      end
   end

   // FIFO storage array
   always_ff @(posedge fst_clk) begin
      if (wr_en_s) mem_r[wr_ptr_r] <= shift_r;
   end

   // FIFO pointers, registered stream outputs, flow control and sticky flags
   always_ff @(posedge fst_clk) begin
      if (!res_n) begin
         wr_ptr_r     <= {FIFO_AW{1'b0}};
         rd_ptr_r     <= {FIFO_AW{1'b0}};
         level_r      <= LEVEL_ZERO;
         m_valid_r    <= 1'b0;
         m_data_r     <= 8'h00;
         cts_n_r      <= 1'b1;
         frame_err_r  <= 1'b0;
         parity_err_r <= 1'b0;
         overrun_r    <= 1'b0;
      end else begin
         if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         rd_ptr_r  <= rd_nx_s;
         level_r   <= level_nx_s;
         m_valid_r <= (level_nx_s != LEVEL_ZERO);
         m_data_r  <= head_s;
         cts_n_r   <= (level_r >= CTS_LEVEL);
         if (ferr_set_s)   frame_err_r <= 1'b1;
         else if (clr_err) frame_err_r <= 1'b0;
         if (perr_set_s)   parity_err_r <= 1'b1;
         else if (clr_err) parity_err_r <= 1'b0;
         if (ovr_set_s)    overrun_r <= 1'b1;
         else if (clr_err) overrun_r <= 1'b0;
      end
   end

   assign cts_n      = cts_n_r;
   assign m_data     = m_data_r;
   assign m_valid    = m_valid_r;
   assign fifo_level = level_r;
   assign frame_err  = frame_err_r;
   assign parity_err = parity_err_r;
   assign overrun    = overrun_r;

endmodule

// File: tb/tb_acia_link_rx.sv
// Bench for acia_link_rx: directed scenarios plus randomized frames checked every cycle
// against a queue-based model of the receive FIFO and sticky flags.
module tb_acia_link_rx;
   localparam int CLK_DIV = 4;
   localparam int BIT     = 16 * CLK_DIV;
   localparam int FIFO_AW = 2;
   localparam int DEPTH   = 4;
   localparam int CTS_TH  = 3;
`ifdef RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic             fst_clk = 1'b0;
   logic             res_n   = 1'b0;
   logic             rxd     = 1'b1;
   logic             m_ready = 1'b0;
   logic             clr_err = 1'b0;
   logic             cts_n, m_valid, frame_err, parity_err, overrun;
   logic [7:0]       m_data;
   logic [FIFO_AW:0] fifo_level;

   int compared   = 0;
   int mismatched = 0;

   // model state
   logic [7:0] q[$];
   logic       exp_ferr = 1'b0, exp_perr = 1'b0, exp_ovr = 1'b0, exp_cts = 1'b1;
   logic       mask = 1'b0, rnd_ready = 1'b0;
   logic       req_valid = 1'b0, req_stop = 1'b1, req_perr = 1'b0;
   logic [7:0] req_byte = 8'h00;

   acia_link_rx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW), .CTS_MARGIN(1), .PARITY_ODD(0)) dut (
      .fst_clk(fst_clk), .res_n(res_n), .rxd(rxd), .cts_n(cts_n),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level),
      .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .clr_err(clr_err)
   );

   always #5 fst_clk = ~fst_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the FIFO is a queue, a finished frame is applied as one event
   always @(posedge fst_clk) begin
      if (!res_n) begin
         q.delete();
         exp_ferr <= 1'b0;
         exp_perr <= 1'b0;
         exp_ovr  <= 1'b0;
         exp_cts  <= 1'b1;
      end else begin
         exp_cts <= (q.size() >= CTS_TH);
         if (m_ready && q.size() > 0) void'(q.pop_front());
         if (clr_err) begin
            exp_ferr <= 1'b0;
            exp_perr <= 1'b0;
            exp_ovr  <= 1'b0;
         end
         if (req_valid) begin
            if (!req_stop) exp_ferr <= 1'b1;
            if (req_perr)  exp_perr <= 1'b1;
            if (req_stop && !req_perr) begin
               if (q.size() >= DEPTH) exp_ovr <= 1'b1;
               else q.push_back(req_byte);
            end
         end
      end
   end

   // Compare every cycle except around the stop-bit sample, whose exact cycle the model does not track
   always @(posedge fst_clk) begin
      #2;
      if (!mask) begin
         chk("m_valid", m_valid, q.size() != 0);
         chk("m_data", m_data, (q.size() != 0) ? q[0] : 8'h00);
         chk("fifo_level", fifo_level, q.size());
         chk("cts_n", cts_n, exp_cts);
         chk("frame_err", frame_err, exp_ferr);
         chk("parity_err", parity_err, exp_perr);
         chk("overrun", overrun, exp_ovr);
      end
   end

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(negedge fst_clk);
         if (rnd_ready) begin
            m_ready = 1'($urandom_range(0, 1));
            clr_err = ($urandom_range(0, 15) == 0);
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic flip);
      rxd = 1'b0;
      idle_cycles(BIT);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         idle_cycles(BIT);
      end
`ifdef RX_PARITY_EN
      rxd = (^d) ^ flip;
      idle_cycles(BIT);
`endif
      rxd     = stop_bit;
      m_ready = 1'b0;
      clr_err = 1'b0;
      mask    = 1'b1;
      repeat (BIT) @(negedge fst_clk);
      rxd       = 1'b1;
      req_byte  = d;
      req_stop  = stop_bit;
      req_perr  = flip & PAR_EN;
      req_valid = 1'b1;
      @(negedge fst_clk);
      req_valid = 1'b0;
      @(negedge fst_clk);
      mask = 1'b0;
   endtask

   task automatic glitch(input int n);
      rxd = 1'b0;
      repeat (n) @(negedge fst_clk);
      rxd = 1'b1;
      idle_cycles(80);
   endtask

   task automatic pop_one();
      m_ready = 1'b1;
      @(negedge fst_clk);
      m_ready = 1'b0;
   endtask

   initial begin
      repeat (5) @(negedge fst_clk);
      chk("rst_cts_n", cts_n, 1'b1);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_level", fifo_level, 0);
      res_n = 1'b1;
      @(negedge fst_clk);
      chk("cts_after_rst", cts_n, 1'b0);
      idle_cycles(20);

      send_frame(8'hA5, 1'b1, 1'b0);
      chk("a5_valid", m_valid, 1'b1);
      chk("a5_data", m_data, 8'hA5);
      chk("a5_level", fifo_level, 1);
      pop_one();
      chk("a5_popped", fifo_level, 0);

      glitch(20);
      chk("glitch_level", fifo_level, 0);
      chk("glitch_ferr", frame_err, 1'b0);

      send_frame(8'h3C, 1'b0, 1'b0);
      chk("3c_ferr", frame_err, 1'b1);
      chk("3c_level", fifo_level, 0);
      clr_err = 1'b1;
      @(negedge fst_clk);
      clr_err = 1'b0;
      chk("3c_cleared", frame_err, 1'b0);

      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1, 1'b0);
         if (i == 3) chk("cts_at_3", cts_n, 1'b1);
      end
      chk("full_level", fifo_level, 4);
      chk("full_overrun", overrun, 1'b1);
      chk("full_cts", cts_n, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         chk("drain_data", m_data, i);
         pop_one();
      end
      @(negedge fst_clk);
      chk("drained_cts", cts_n, 1'b0);
      chk("drained_level", fifo_level, 0);
      clr_err = 1'b1;
      @(negedge fst_clk);
      clr_err = 1'b0;

`ifdef RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0);
      chk("par_ok_level", fifo_level, 1);
      send_frame(8'h07, 1'b1, 1'b1);
      chk("par_bad_flag", parity_err, 1'b1);
      chk("par_bad_level", fifo_level, 1);
      pop_one();
`endif

      rnd_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (n == 20) begin
            rxd = 1'b0;
            idle_cycles($urandom_range(100, 500));
            res_n   = 1'b0;
            rxd     = 1'b1;
            m_ready = 1'b0;
            clr_err = 1'b0;
            repeat (4) @(negedge fst_clk);
            chk("midrst_level", fifo_level, 0);
            chk("midrst_valid", m_valid, 1'b0);
            chk("midrst_cts", cts_n, 1'b1);
            res_n = 1'b1;
         end else if (r == 0) begin
            glitch($urandom_range(1, 20));
         end else begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0),
                       ($urandom_range(0, 3) == 0));
         end
         idle_cycles($urandom_range(4, 40));
      end
      rnd_ready = 1'b0;
      clr_err   = 1'b0;
      m_ready   = 1'b1;
      repeat (10) @(negedge fst_clk);
      m_ready = 1'b0;
      @(negedge fst_clk);
      chk("final_level", fifo_level, 0);
      chk("final_valid", m_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
